// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the 5-stage core: load-use stalls, branch squash,
// memory-wait freeze with timeout halt, and saturating stall/flush performance counters.
module hazard_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             perf_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] load_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt
);

    localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int NUM_CNT = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_bubble;
    } ctl_t;

    localparam ctl_t CTL_NORMAL = 7'b1111_000;
    localparam ctl_t CTL_BRANCH = 7'b1111_110;
    localparam ctl_t CTL_LOAD   = 7'b0011_010;
    localparam ctl_t CTL_FREEZE = 7'b0000_001;

    state_t                          state;
    logic [WAIT_W-1:0]               wait_cnt;
    logic [WAIT_W-1:0]               wait_inc;
    logic                            timeout_hit;
    logic                            in_halt;
    logic                            mem_stall;
    logic                            load_use;
    logic                            act_load;
    logic                            act_flush;
    logic                            act_wait;
    logic                            clr_eff;
    ctl_t                            ctl;
    logic [NUM_CNT-1:0]              perf_inc;
    logic [NUM_CNT-1:0][CNT_W-1:0]   perf_q;

    assign mem_stall = mem_req & ~mem_ready;
    assign load_use  = ex_mem_read & (ex_rd != 5'd0) &
                       ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));

    // Reset is asynchronous, so outputs must read as RUN while arst is high.
    assign in_halt = (state == HALT) & ~arst;

    assign act_wait  = ~in_halt & mem_stall;
    assign act_flush = ~in_halt & ~mem_stall & ex_branch_taken;
    assign act_load  = ~in_halt & ~mem_stall & ~ex_branch_taken & load_use;
    assign clr_eff   = ~in_halt & perf_clr;

    assign wait_inc    = wait_cnt + WAIT_W'(1);
    assign timeout_hit = (wait_inc == WAIT_W'(MEM_TIMEOUT));

    always_comb begin
        ctl = CTL_NORMAL;
        if (in_halt || mem_stall)
            ctl = CTL_FREEZE;
        else if (ex_branch_taken)
            ctl = CTL_BRANCH;
        else if (load_use)
            ctl = CTL_LOAD;
    end

    assign {pc_write, if_id_write, id_ex_write, ex_mem_write,
            if_id_flush, id_ex_flush, mem_wb_bubble} = ctl;
    assign halted = in_halt;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN, MEM_WAIT: begin
                    if (mem_stall) begin
                        wait_cnt <= wait_inc;
                        state    <= timeout_hit ? HALT : MEM_WAIT;
                    end else begin
                        wait_cnt <= '0;
                        state    <= RUN;
                    end
                end
                HALT:    state <= HALT;
                default: state <= RUN;
            endcase
        end
    end

    // Counter slots: 0 = load-use stalls, 1 = branch flushes, 2 = memory wait cycles.
    assign perf_inc = {act_wait, act_flush, act_load};

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            perf_q <= '0;
        end else if (clr_eff) begin
            perf_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (perf_inc[i] && (perf_q[i] != '1))
                    perf_q[i] <= perf_q[i] + CNT_W'(1);
            end
        end
    end

    assign load_stall_cnt = perf_q[0];
    assign flush_cnt      = perf_q[1];
    assign mem_wait_cnt   = perf_q[2];

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: decode table, hand-written multi-cycle
// sequences, and randomized stimulus against a cycle-level behavioural model.
module tb_hazard_controller;

    localparam int TO    = 4;
    localparam int CW    = 3;
    localparam int CMAX  = (1 << CW) - 1;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       use1;
        logic       use2;
        logic       mread;
        logic       br;
        logic       mreq;
        logic       mrdy;
        logic       clr;
    } stim_t;

    typedef struct packed {
        stim_t      s;
        logic [6:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          arst;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
    logic          mem_req, mem_ready, perf_clr;
    logic          pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic          if_id_flush, id_ex_flush, mem_wb_bubble, halted;
    logic [CW-1:0] load_stall_cnt, flush_cnt, mem_wait_cnt;
    logic [6:0]    dut_ctl;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state
    bit m_halt;
    int m_wait, m_ls, m_fl, m_mw;

    hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .arst(arst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .perf_clr(perf_clr),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_bubble(mem_wb_bubble), .halted(halted),
        .load_stall_cnt(load_stall_cnt), .flush_cnt(flush_cnt), .mem_wait_cnt(mem_wait_cnt)
    );

    assign dut_ctl = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                      if_id_flush, id_ex_flush, mem_wb_bubble};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // flags = {use1, use2, mread, br, mreq, mrdy, clr}
    function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [6:0] flags);
        return {rs1, rs2, rd, flags};
    endfunction

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    function automatic bit is_stall(input stim_t s);
        return s.mreq && !s.mrdy;
    endfunction

    function automatic bit is_lu(input stim_t s);
        return s.mread && (s.rd != 0) &&
               ((s.use1 && s.rd == s.rs1) || (s.use2 && s.rd == s.rs2));
    endfunction

    function automatic logic [6:0] model_ctl(input stim_t s);
        if (m_halt || is_stall(s)) return 7'b0000_001;
        if (s.br)                  return 7'b1111_110;
        if (is_lu(s))              return 7'b0011_010;
        return 7'b1111_000;
    endfunction

    task automatic model_update(input stim_t s);
        if (!m_halt) begin
            if (is_stall(s)) begin
                m_wait++;
                m_mw = sat(m_mw);
                if (m_wait == TO) m_halt = 1;
            end else begin
                m_wait = 0;
                if (s.br)          m_fl = sat(m_fl);
                else if (is_lu(s)) m_ls = sat(m_ls);
            end
            if (s.clr) begin
                m_ls = 0; m_fl = 0; m_mw = 0;
            end
        end
    endtask

    task automatic drive(input stim_t s);
        id_rs1 = s.rs1; id_rs2 = s.rs2; ex_rd = s.rd;
        id_use_rs1 = s.use1; id_use_rs2 = s.use2;
        ex_mem_read = s.mread; ex_branch_taken = s.br;
        mem_req = s.mreq; mem_ready = s.mrdy; perf_clr = s.clr;
    endtask

    // Cycle split in two halves so table vectors can add their own check mid-cycle.
    task automatic first_half(input stim_t s);
        drive(s);
        @(negedge clk);
        chk("ctl", 32'(dut_ctl), 32'(model_ctl(s)));
        chk("halted_comb", 32'(halted), 32'(m_halt));
    endtask

    task automatic second_half(input stim_t s);
        @(posedge clk);
        model_update(s);
        #1;
        chk("load_stall_cnt", 32'(load_stall_cnt), 32'(m_ls));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_fl));
        chk("mem_wait_cnt", 32'(mem_wait_cnt), 32'(m_mw));
        chk("halted", 32'(halted), 32'(m_halt));
    endtask

    task automatic run_cycle(input stim_t s);
        first_half(s);
        second_half(s);
    endtask

    task automatic do_reset();
        drive('0);
        arst = 1'b1;
        #1;
        m_halt = 0; m_wait = 0; m_ls = 0; m_fl = 0; m_mw = 0;
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_ctl", 32'(dut_ctl), 32'h78);
        chk("rst_ls", 32'(load_stall_cnt), 32'd0);
        chk("rst_fl", 32'(flush_cnt), 32'd0);
        chk("rst_mw", 32'(mem_wait_cnt), 32'd0);
        @(posedge clk);
        #1;
        arst = 1'b0;
    endtask

    vec_t  tbl [12];
    stim_t st, lu_s, stall_s;
    int    ls0, fl0;

    initial begin
        tbl[0]  = '{mk(5'd5, 5'd0, 5'd5, 7'b1010000), 7'b0011_010};
        tbl[1]  = '{mk(5'd5, 5'd0, 5'd0, 7'b1010000), 7'b1111_000};
        tbl[2]  = '{mk(5'd0, 5'd0, 5'd0, 7'b1110000), 7'b1111_000};
        tbl[3]  = '{mk(5'd1, 5'd9, 5'd9, 7'b0110000), 7'b0011_010};
        tbl[4]  = '{mk(5'd9, 5'd3, 5'd9, 7'b0110000), 7'b1111_000};
        tbl[5]  = '{mk(5'd7, 5'd0, 5'd7, 7'b1000000), 7'b1111_000};
        tbl[6]  = '{mk(5'd0, 5'd0, 5'd0, 7'b0001000), 7'b1111_110};
        tbl[7]  = '{mk(5'd4, 5'd0, 5'd4, 7'b1011000), 7'b1111_110};
        tbl[8]  = '{mk(5'd0, 5'd0, 5'd0, 7'b0000110), 7'b1111_000};
        tbl[9]  = '{mk(5'd0, 5'd0, 5'd0, 7'b0000010), 7'b1111_000};
        tbl[10] = '{mk(5'd0, 5'd0, 5'd0, 7'b0000100), 7'b0000_001};
        tbl[11] = '{mk(5'd4, 5'd0, 5'd4, 7'b1011100), 7'b0000_001};

        lu_s    = mk(5'd5, 5'd0, 5'd5, 7'b1010000);
        stall_s = mk(5'd0, 5'd0, 5'd0, 7'b0000100);

        do_reset();

        foreach (tbl[i]) begin
            first_half(tbl[i].s);
            chk($sformatf("tbl%0d", i), 32'(dut_ctl), 32'(tbl[i].exp));
            second_half(tbl[i].s);
        end

        // Memory wait of 3 cycles, then ready
        run_cycle(mk(5'd0, 5'd0, 5'd0, 7'b0000001));
        repeat (3) run_cycle(stall_s);
        run_cycle(mk(5'd0, 5'd0, 5'd0, 7'b0000110));
        chk("memwait_total", 32'(mem_wait_cnt), 32'd3);
        repeat (3) run_cycle(stall_s);
        run_cycle(mk(5'd0, 5'd0, 5'd0, 7'b0000000));
        chk("memwait_not_halted", 32'(halted), 32'd0);

        // Stall + branch + load-use: freeze, then branch wins on ready
        run_cycle(mk(5'd0, 5'd0, 5'd0, 7'b0000001));
        ls0 = m_ls; fl0 = m_fl;
        repeat (2) run_cycle(mk(5'd6, 5'd0, 5'd6, 7'b1011100));
        first_half(mk(5'd6, 5'd0, 5'd6, 7'b1011110));
        chk("simul_ctl", 32'(dut_ctl), 32'h7E);
        second_half(mk(5'd6, 5'd0, 5'd6, 7'b1011110));
        chk("simul_fl", 32'(flush_cnt), 32'(fl0 + 1));
        chk("simul_ls", 32'(load_stall_cnt), 32'(ls0));

        // Saturation, then clear together with a load-use stall
        run_cycle(mk(5'd0, 5'd0, 5'd0, 7'b0000001));
        repeat (9) run_cycle(lu_s);
        chk("sat_ls", 32'(load_stall_cnt), 32'd7);
        run_cycle(mk(5'd5, 5'd0, 5'd5, 7'b1010001));
        chk("clr_ls", 32'(load_stall_cnt), 32'd0);

        // Timeout after TO stall cycles
        repeat (TO - 1) run_cycle(stall_s);
        chk("to_not_yet", 32'(halted), 32'd0);
        run_cycle(stall_s);
        chk("to_halted", 32'(halted), 32'd1);
        run_cycle(mk(5'd5, 5'd0, 5'd5, 7'b1011111));
        chk("halt_sticky", 32'(halted), 32'd1);
        chk("halt_ctl", 32'(dut_ctl), 32'h01);
        chk("halt_mw", 32'(mem_wait_cnt), 32'd4);
        do_reset();

        // Randomized stimulus against the model
        for (int n = 0; n < 600; n++) begin
            if (m_halt && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else begin
                st.rs1   = 5'($urandom_range(0, 7));
                st.rs2   = 5'($urandom_range(0, 7));
                st.rd    = 5'($urandom_range(0, 7));
                st.use1  = 1'($urandom_range(0, 1));
                st.use2  = 1'($urandom_range(0, 1));
                st.mread = 1'($urandom_range(0, 1));
                st.br    = ($urandom_range(0, 4) == 0);
                st.mreq  = ($urandom_range(0, 9) < 4);
                st.mrdy  = 1'($urandom_range(0, 1));
                st.clr   = ($urandom_range(0, 19) == 0);
                run_cycle(st);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
